// File: rtl/ghash_ctrl_pkg.sv
// ghash_ctrl_pkg: shared GCM widths and GHASH controller state encoding
package ghash_ctrl_pkg;
  localparam int GCM_BLOCK_W = 128;
  localparam int GCM_LEN_W = 64;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_LENBLK,
    S_MUL,
    S_GAP,
    S_DONE
  } state_e;
endpackage

// File: rtl/ghash_ctrl_if.sv
// ghash_ctrl_if: block source, multiplier and result signals of the GHASH controller
// The leftmost bit of every 128-bit vector is GCM coefficient x^0, i.e. bit 0 of gfmul_v2's [0:127] view.
interface ghash_ctrl_if;
  import ghash_ctrl_pkg::*;
  logic [GCM_BLOCK_W-1:0] iHashkey;
  logic                   iHashkey_valid;
  logic                   iStart;
  logic [GCM_LEN_W-1:0]   iLen_aad;
  logic [GCM_LEN_W-1:0]   iLen_ct;
  logic [GCM_BLOCK_W-1:0] iBlock;
  logic                   iBlock_valid;
  logic                   iBlock_last;
  logic                   oBlock_ready;
  logic [GCM_BLOCK_W-1:0] oMul_ctext;
  logic                   oMul_ctext_valid;
  logic [GCM_BLOCK_W-1:0] oMul_hashkey;
  logic                   oMul_hashkey_valid;
  logic [GCM_BLOCK_W-1:0] iMul_result;
  logic                   iMul_result_valid;
  logic [GCM_BLOCK_W-1:0] oGhash;
  logic                   oGhash_valid;
  logic                   oBusy;
  logic                   oError;
  modport master (
    input  iHashkey, iHashkey_valid, iStart, iLen_aad, iLen_ct,
    input  iBlock, iBlock_valid, iBlock_last, iMul_result, iMul_result_valid,
    output oBlock_ready, oMul_ctext, oMul_ctext_valid, oMul_hashkey, oMul_hashkey_valid,
    output oGhash, oGhash_valid, oBusy, oError
  );
  modport slave (
    output iHashkey, iHashkey_valid, iStart, iLen_aad, iLen_ct,
    output iBlock, iBlock_valid, iBlock_last, iMul_result, iMul_result_valid,
    input  oBlock_ready, oMul_ctext, oMul_ctext_valid, oMul_hashkey, oMul_hashkey_valid,
    input  oGhash, oGhash_valid, oBusy, oError
  );
endinterface

// File: rtl/ghash_ctrl.sv
// ghash_ctrl: sequences Y(i) = (Y(i-1) ^ X(i)) * H through an external gfmul_v2, then the length block
module ghash_ctrl
  import ghash_ctrl_pkg::*;
#(
  parameter int MUL_TIMEOUT = 255
) (
  input logic          iClk,
  input logic          iRst,
  ghash_ctrl_if.master bus
);
  localparam int CW = $clog2(MUL_TIMEOUT + 1);
  state_e                   state_q, state_d;
  logic [GCM_BLOCK_W-1:0]   h_q, h_d, y_q, y_d, ctext_q, ctext_d, ghash_q, ghash_d;
  logic [2*GCM_LEN_W-1:0]   len_q, len_d;
  logic                     key_q, key_d, last_q, last_d, lenph_q, lenph_d;
  logic                     gvalid_q, gvalid_d, err_q, err_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= S_IDLE;
      h_q      <= '0;
      y_q      <= '0;
      ctext_q  <= '0;
      ghash_q  <= '0;
      len_q    <= '0;
      key_q    <= 1'b0;
      last_q   <= 1'b0;
      lenph_q  <= 1'b0;
      gvalid_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      y_q      <= y_d;
      ctext_q  <= ctext_d;
      ghash_q  <= ghash_d;
      len_q    <= len_d;
      key_q    <= key_d;
      last_q   <= last_d;
      lenph_q  <= lenph_d;
      gvalid_q <= gvalid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    y_d      = y_q;
    ctext_d  = ctext_q;
    ghash_d  = ghash_q;
    len_d    = len_q;
    key_d    = key_q;
    last_d   = last_q;
    lenph_d  = lenph_q;
    gvalid_d = 1'b0;
    err_d    = 1'b0;
    cnt_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.iHashkey_valid) begin
          h_d   = bus.iHashkey;
          key_d = 1'b1;
        end
        if (bus.iStart && key_q) begin
          y_d     = '0;
          len_d   = {bus.iLen_aad, bus.iLen_ct};
          lenph_d = 1'b0;
          last_d  = 1'b0;
          state_d = (bus.iLen_aad == '0 && bus.iLen_ct == '0) ? S_LENBLK : S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (bus.iBlock_valid) begin
          ctext_d = y_q ^ bus.iBlock;
          last_d  = bus.iBlock_last;
          state_d = S_MUL;
        end
      end
      S_LENBLK: begin
        ctext_d = y_q ^ len_q;
        lenph_d = 1'b1;
        state_d = S_MUL;
      end
      S_MUL: begin
        // a result arriving on the final allowed cycle still wins over the timeout
        if (bus.iMul_result_valid) begin
          y_d     = bus.iMul_result;
          state_d = S_GAP;
        end else if (cnt_q == CW'(MUL_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: state_d = lenph_q ? S_DONE : last_q ? S_LENBLK : S_ACCEPT;
      S_DONE: begin
        ghash_d  = y_q;
        gvalid_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign bus.oBlock_ready       = state_q == S_ACCEPT;
  assign bus.oMul_ctext         = ctext_q;
  assign bus.oMul_ctext_valid   = state_q == S_MUL;
  assign bus.oMul_hashkey       = h_q;
  assign bus.oMul_hashkey_valid = state_q == S_MUL;
  assign bus.oGhash             = ghash_q;
  assign bus.oGhash_valid       = gvalid_q;
  assign bus.oBusy              = state_q != S_IDLE;
  assign bus.oError             = err_q;
endmodule

// File: tb/tb_ghash_ctrl.sv
// tb_ghash_ctrl: randomized GHASH messages against a behavioural GF(2^128) reference model
module tb_ghash_ctrl;
  import ghash_ctrl_pkg::*;
  localparam int TO = 255;
  localparam logic [127:0] H0 = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
  localparam logic [127:0] X0 = 128'h0388DACE60B6A392F328C2B971B2FE78;
  localparam logic [127:0] P0 = 128'h5E2EC746917062882C85B0685353DEB7;
  localparam logic [127:0] G0 = 128'hF38CBB1AD69223DCC3457AE5B6B0F885;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0, n_pass = 0;
  int cyc = 0, gv_cnt = 0, err_cnt = 0, mul_entry = 0, err_cyc = 0, viol = 0;
  int n_resp = 0, stop_at = -1;
  logic prev_v = 1'b0;
  logic [127:0] prev_c = '0;
  logic [127:0] ops_q[$];
  logic [127:0] msg_q[$];
  logic [127:0] h_cur = '0;
  ghash_ctrl_if bus();
  ghash_ctrl #(.MUL_TIMEOUT(TO)) dut (.iClk(clk), .iRst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'hE1, 120'h0}) : (v >> 1);
    end
    return z;
  endfunction
  function automatic logic [127:0] ref_ghash(input logic [63:0] la, input logic [63:0] lc);
    logic [127:0] y;
    y = '0;
    foreach (msg_q[i]) y = gf_mul(y ^ msg_q[i], h_cur);
    return gf_mul(y ^ {la, lc}, h_cur);
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  function automatic logic [127:0] op_at(input int i);
    return (i < ops_q.size()) ? ops_q[i] : 'x;
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.oMul_ctext_valid && !prev_v) begin
      ops_q.push_back(bus.oMul_ctext);
      mul_entry = cyc;
    end
    if (bus.oMul_ctext_valid && (!bus.oBusy || bus.oBlock_ready)) viol++;
    if (bus.oMul_hashkey_valid !== bus.oMul_ctext_valid) viol++;
    if (prev_v && bus.oMul_ctext_valid && (bus.iMul_result_valid || bus.oMul_ctext !== prev_c)) viol++;
    if (bus.oGhash_valid) gv_cnt++;
    if (bus.oError) begin
      err_cnt++;
      err_cyc = cyc;
    end
    prev_v = bus.oMul_ctext_valid;
    prev_c = bus.oMul_ctext;
  end
  initial begin
    bus.iMul_result = '0;
    bus.iMul_result_valid = 1'b0;
    forever begin
      @(negedge clk);
      bus.iMul_result_valid = 1'b0;
      if (bus.oMul_ctext_valid && n_resp != stop_at) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (bus.oMul_ctext_valid) begin
          bus.iMul_result = gf_mul(bus.oMul_ctext, bus.oMul_hashkey);
          bus.iMul_result_valid = 1'b1;
          n_resp++;
        end
      end
    end
  end
  task automatic load_key(input logic [127:0] h);
    bus.iHashkey = h;
    bus.iHashkey_valid = 1'b1;
    @(negedge clk);
    bus.iHashkey_valid = 1'b0;
    bus.iHashkey = rnd128();
    h_cur = h;
  endtask
  task automatic start_msg(input logic [63:0] la, input logic [63:0] lc);
    bus.iLen_aad = la;
    bus.iLen_ct = lc;
    bus.iStart = 1'b1;
    @(negedge clk);
    bus.iStart = 1'b0;
    bus.iLen_aad = {$urandom(), $urandom()};
    bus.iLen_ct = {$urandom(), $urandom()};
  endtask
  task automatic send_blk(input logic [127:0] blk, input logic last);
    int n;
    bus.iBlock = blk;
    bus.iBlock_last = last;
    bus.iBlock_valid = 1'b1;
    n = 0;
    while (!bus.oBlock_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("blk_accept_timeout", 128'(bus.oBlock_ready), 128'(1));
    @(negedge clk);
    bus.iBlock_valid = 1'b0;
    bus.iBlock_last = 1'b0;
    bus.iBlock = rnd128();
  endtask
  task automatic run_msg(input logic [63:0] la, input logic [63:0] lc, input int maxgap,
                         input bit poke, input string tag, input logic [127:0] exp);
    int g0, n;
    g0 = gv_cnt;
    start_msg(la, lc);
    foreach (msg_q[i]) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      if (poke && i == 1) begin
        bus.iStart = 1'b1;
        bus.iLen_aad = {$urandom(), $urandom()};
        bus.iHashkey = rnd128();
        bus.iHashkey_valid = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        bus.iHashkey_valid = 1'b0;
        chk({tag, "_busy_poke"}, 128'(bus.oBusy), 128'(1));
      end
      send_blk(msg_q[i], i == msg_q.size() - 1);
    end
    n = 0;
    while (gv_cnt == g0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 128'(gv_cnt != g0), 128'(1));
    chk({tag, "_ghash"}, bus.oGhash, exp);
  endtask
  task automatic add_bytes(input int nbytes);
    logic [127:0] m;
    for (int k = 0; k < nbytes; k += 16) begin
      m = '1;
      m = m >> (((nbytes - k) >= 16 ? 16 : nbytes - k) * 8);
      msg_q.push_back(rnd128() & ~m);
    end
  endtask
  task automatic gen_msg(output logic [63:0] la, output logic [63:0] lc);
    int ab, cb;
    msg_q.delete();
    ab = $urandom_range(0, 40);
    cb = $urandom_range(ab == 0 ? 1 : 0, 60);
    add_bytes(ab);
    add_bytes(cb);
    la = 64'(ab * 8);
    lc = 64'(cb * 8);
  endtask
  initial begin
    int ops0, g0, e0, n;
    logic [63:0] la, lc;
    logic [127:0] r;
    bus.iHashkey = '0;
    bus.iHashkey_valid = 1'b0;
    bus.iStart = 1'b0;
    bus.iLen_aad = '0;
    bus.iLen_ct = '0;
    bus.iBlock = '0;
    bus.iBlock_valid = 1'b0;
    bus.iBlock_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(bus.oBusy), 128'(0));
    chk("rst_ready", 128'(bus.oBlock_ready), 128'(0));
    chk("rst_mvalid", 128'(bus.oMul_ctext_valid), 128'(0));
    chk("rst_hkey", bus.oMul_hashkey, '0);
    chk("rst_ghash", bus.oGhash, '0);
    chk("rst_err", 128'(bus.oError), 128'(0));
    rst = 1'b0;
    start_msg(64'd0, 64'd128);
    @(negedge clk);
    chk("nokey_busy", 128'(bus.oBusy), 128'(0));
    load_key(H0);
    chk("key_latched", bus.oMul_hashkey, H0);
    msg_q.delete();
    ops0 = ops_q.size();
    g0 = gv_cnt;
    run_msg(64'd0, 64'd0, 0, 1'b0, "empty", 128'd0);
    repeat (4) @(negedge clk);
    chk("empty_pulses", 128'(gv_cnt - g0), 128'(1));
    chk("empty_ops", 128'(ops_q.size() - ops0), 128'(1));
    chk("empty_op", op_at(ops0), 128'd0);
    msg_q = '{X0};
    ops0 = ops_q.size();
    run_msg(64'd0, 64'd128, 0, 1'b0, "one_blk", G0);
    chk("one_op0", op_at(ops0), X0);
    chk("one_op1", op_at(ops0 + 1), P0 ^ 128'd128);
    msg_q.delete();
    repeat (4) msg_q.push_back(rnd128());
    r = ref_ghash(64'd128, 64'd384);
    run_msg(64'd128, 64'd384, 0, 1'b0, "nogap", r);
    run_msg(64'd128, 64'd384, 7, 1'b1, "stall", r);
    for (int t = 0; t < 6; t++) begin
      gen_msg(la, lc);
      run_msg(la, lc, 3, 1'b0, $sformatf("rand%0d", t), ref_ghash(la, lc));
    end
    msg_q = '{X0};
    stop_at = n_resp;
    e0 = err_cnt;
    start_msg(64'd0, 64'd128);
    send_blk(X0, 1'b1);
    n = 0;
    while (err_cnt == e0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("to_seen", 128'(err_cnt - e0), 128'(1));
    chk("to_cycles", 128'(err_cyc - mul_entry), 128'(TO));
    chk("to_busy", 128'(bus.oBusy), 128'(0));
    chk("to_mvalid", 128'(bus.oMul_ctext_valid), 128'(0));
    @(negedge clk);
    chk("to_pulse", 128'(bus.oError), 128'(0));
    stop_at = -1;
    run_msg(64'd0, 64'd128, 0, 1'b0, "after_to", G0);
    msg_q.delete();
    repeat (3) msg_q.push_back(rnd128());
    stop_at = n_resp + 1;
    ops0 = ops_q.size();
    start_msg(64'd0, 64'd384);
    send_blk(msg_q[0], 1'b0);
    send_blk(msg_q[1], 1'b0);
    n = 0;
    while (ops_q.size() < ops0 + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mrst_in_mul", 128'(bus.oMul_ctext_valid), 128'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_busy", 128'(bus.oBusy), 128'(0));
    chk("mrst_mvalid", 128'(bus.oMul_ctext_valid), 128'(0));
    chk("mrst_ctext", bus.oMul_ctext, '0);
    chk("mrst_hkey", bus.oMul_hashkey, '0);
    chk("mrst_ghash", bus.oGhash, '0);
    chk("mrst_gvalid", 128'(bus.oGhash_valid), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    stop_at = -1;
    start_msg(64'd0, 64'd384);
    @(negedge clk);
    chk("mrst_nokey", 128'(bus.oBusy), 128'(0));
    load_key(rnd128());
    run_msg(64'd0, 64'd384, 2, 1'b0, "post_rst", ref_ghash(64'd0, 64'd384));
    chk("protocol", 128'(viol), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
